ppu_render_sequencer: RTL and testbench

- Frame-level controller that drives ppu_vram_load_fsm tile by tile across the visible screen.
- Generates curr_row and curr_col, and runs the start/busy handshake with the loader.
- Runs a vblank interval with NMI generation.
- Arbitrates PPU VRAM between the loader (visible rows) and CPU writes (vblank or idle only).
- Sits between the CPU register block (ppu_ctrl1 and scroll) and ppu_vram_load_fsm.

---
 rtl/ppu_render_sequencer_pkg.sv | 38 +++
 rtl/ppu_render_sequencer_if.sv | 28 ++
 rtl/ppu_cycle_counter.sv | 32 +++
 rtl/ppu_render_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_ppu_render_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ppu_render_sequencer_pkg.sv
// ppu_pkg: shared types and constants for the PPU render sequencer.
//   render_state_t  - frame sequencer states
//   SCREEN_ROWS     - visible scanlines per frame
//   TILE_W          - pixel step of curr_col per tile load
//   NES_WIDTH       - visible screen width in pixels
//   first_tile_col  - starting column for a given fine scroll
//   last_tile_col   - column of the final tile in a row for a given fine scroll
package ppu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ACK,
        ST_WAIT,
        ST_NEXT,
        ST_VBL
    } render_state_t;

    localparam int unsigned SCREEN_ROWS = 240;
    localparam int unsigned TILE_W      = 8;
    localparam int unsigned NES_WIDTH   = 256;

    // Row starts fx pixels left of the screen edge (9-bit two's complement).
    function automatic logic [8:0] first_tile_col(input logic [2:0] fx);
        return 9'd0 - {6'd0, fx};
    endfunction

    // With no fine scroll the row is exactly 32 tiles; any non-zero scroll
    // needs a 33rd tile to cover the right edge.
    function automatic logic [8:0] last_tile_col(input logic [2:0] fx,
                                                 input int unsigned tile_w);
        if (fx == 3'd0) begin
            return 9'(NES_WIDTH - tile_w);
        end
        return 9'(NES_WIDTH) - {6'd0, fx};
    endfunction

endpackage

// File: rtl/ppu_render_sequencer_if.sv
// ppu_render_sequencer_if: tile-load handshake between the render sequencer
// and ppu_vram_load_fsm.
//   load_start - one-cycle start pulse (sequencer -> loader)
//   load_busy  - loader busy (loader -> sequencer)
//   curr_row   - row presented to the loader
//   curr_col   - column presented to the loader (two's complement)
interface ppu_render_sequencer_if;

    logic       load_start;
    logic       load_busy;
    logic [8:0] curr_row;
    logic [8:0] curr_col;

    modport master (
        output load_start,
        output curr_row,
        output curr_col,
        input  load_busy
    );

    modport slave (
        input  load_start,
        input  curr_row,
        input  curr_col,
        output load_busy
    );

endinterface

// File: rtl/ppu_cycle_counter.sv
// ppu_cycle_counter: loadable down-counter with terminal-count flag.
//   clk, rst   - clock, synchronous active-high reset (count -> 0)
//   load       - load load_value (takes priority over en)
//   en         - decrement by one, saturating at zero
//   load_value - value loaded on load
//   count      - current count
//   tc         - high while count is zero
module ppu_cycle_counter #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/ppu_render_sequencer.sv
// ppu_render_sequencer: frame-level controller walking ppu_vram_load_fsm
// tile by tile across the visible screen, then running vblank with NMI.
//   clk, rst       - clock, synchronous active-high reset
//   enable         - rendering enable
//   ppu_ctrl1      - bit 7 enables NMI
//   fine_x         - horizontal fine scroll, latched at frame start
//   ld             - loader handshake (load_start/load_busy/curr_row/curr_col)
//   cpu_vram_req   - CPU wants the VRAM write port
//   cpu_vram_grant - CPU may write VRAM this cycle (IDLE or VBL only)
//   status_read    - CPU status read; clears vblank
//   vblank, nmi    - vblank flag and NMI request level
//   frame_done     - one-cycle pulse at end of the last visible tile
//   load_error     - sticky loader-timeout flag
module ppu_render_sequencer
    import ppu_pkg::*;
#(
    parameter int unsigned SCREEN_ROWS   = ppu_pkg::SCREEN_ROWS,
    parameter int unsigned TILE_W        = ppu_pkg::TILE_W,
    parameter int unsigned VBLANK_CYCLES = 2048,
    parameter int unsigned LOAD_TIMEOUT  = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [7:0]             ppu_ctrl1,
    input  logic [2:0]             fine_x,
    ppu_render_sequencer_if.master ld,
    input  logic                   cpu_vram_req,
    output logic                   cpu_vram_grant,
    input  logic                   status_read,
    output logic                   vblank,
    output logic                   nmi,
    output logic                   frame_done,
    output logic                   load_error
);

    localparam int unsigned WD_W = $clog2(LOAD_TIMEOUT + 1);
    localparam int unsigned VB_W = $clog2(VBLANK_CYCLES + 1);

    render_state_t state, state_n;
    logic [8:0]    row, row_n;
    logic [8:0]    col, col_n;
    logic [2:0]    fx_lat, fx_n;
    logic          vblank_n;
    logic          set_vblank, clr_vblank, err_set;
    logic          issue_c, done_c;
    logic          last_tile, last_row;

    logic            wd_load, wd_en, wd_tc;
    logic            vb_load, vb_en, vb_tc;
    logic [WD_W-1:0] wd_count_unused;
    logic [VB_W-1:0] vb_count_unused;
    logic            ctrl_unused;

    assign ctrl_unused = ^ppu_ctrl1[6:0];

    ppu_cycle_counter #(.WIDTH(WD_W)) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .load       (wd_load),
        .en         (wd_en),
        .load_value (WD_W'(LOAD_TIMEOUT - 1)),
        .count      (wd_count_unused),
        .tc         (wd_tc)
    );

    ppu_cycle_counter #(.WIDTH(VB_W)) u_vblank_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (vb_load),
        .en         (vb_en),
        .load_value (VB_W'(VBLANK_CYCLES - 1)),
        .count      (vb_count_unused),
        .tc         (vb_tc)
    );

    assign last_tile = (col == last_tile_col(fx_lat, TILE_W));
    assign last_row  = (row == 9'(SCREEN_ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            row        <= '0;
            col        <= '0;
            fx_lat     <= '0;
            vblank     <= 1'b0;
            nmi        <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state  <= state_n;
            row    <= row_n;
            col    <= col_n;
            fx_lat <= fx_n;
            vblank <= vblank_n;
            // Registered from the next flag value so nmi tracks vblank edges
            // exactly and follows a ctrl1 write one cycle later.
            nmi    <= vblank_n & ppu_ctrl1[7];
            if (err_set) begin
                load_error <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n    = state;
        row_n      = row;
        col_n      = col;
        fx_n       = fx_lat;
        set_vblank = 1'b0;
        clr_vblank = 1'b0;
        err_set    = 1'b0;
        issue_c    = 1'b0;
        done_c     = 1'b0;
        wd_load    = 1'b0;
        wd_en      = 1'b0;
        vb_load    = 1'b0;
        vb_en      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (enable) begin
                    fx_n    = fine_x;
                    row_n   = '0;
                    col_n   = first_tile_col(fine_x);
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issue_c = 1'b1;
                state_n = ST_ACK;
            end
            ST_ACK: begin
                wd_load = 1'b1;
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (!ld.load_busy) begin
                    state_n = ST_NEXT;
                end else if (wd_tc) begin
                    err_set = 1'b1;
                    state_n = ST_NEXT;
                end else begin
                    wd_en = 1'b1;
                end
            end
            ST_NEXT: begin
                if (last_tile && last_row) begin
                    done_c     = 1'b1;
                    set_vblank = 1'b1;
                    vb_load    = 1'b1;
                    row_n      = '0;
                    col_n      = first_tile_col(fx_lat);
                    state_n    = ST_VBL;
                end else if (!enable) begin
                    state_n = ST_IDLE;
                end else begin
                    if (last_tile) begin
                        row_n = row + 9'd1;
                        col_n = first_tile_col(fx_lat);
                    end else begin
                        col_n = col + 9'(TILE_W);
                    end
                    state_n = ST_ISSUE;
                end
            end
            ST_VBL: begin
                vb_en = 1'b1;
                if (vb_tc) begin
                    clr_vblank = 1'b1;
                    if (enable) begin
                        fx_n    = fine_x;
                        row_n   = '0;
                        col_n   = first_tile_col(fine_x);
                        state_n = ST_ISSUE;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // A new vblank beats a simultaneous status read.
        if (set_vblank) begin
            vblank_n = 1'b1;
        end else if (status_read || clr_vblank) begin
            vblank_n = 1'b0;
        end else begin
            vblank_n = vblank;
        end
    end

    // Pulses are masked by rst so a reset landing on ISSUE or the frame-end
    // NEXT cycle never leaks a start or done pulse.
    assign ld.load_start  = issue_c & ~rst;
    assign frame_done     = done_c & ~rst;
    assign ld.curr_row    = row;
    assign ld.curr_col    = col;
    assign cpu_vram_grant = cpu_vram_req & ((state == ST_IDLE) || (state == ST_VBL));

endmodule

// File: tb/tb_ppu_render_sequencer.sv
// tb_ppu_render_sequencer: randomized self-checking bench. Expected tile
// sequences are generated from the screen geometry with plain arithmetic;
// a loader model holds busy for a random number of cycles per tile.
module tb_ppu_render_sequencer;

    localparam int unsigned ROWS = 6;
    localparam int unsigned TW   = 8;
    localparam int unsigned VBL  = 100;
    localparam int unsigned TMO  = 512;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] ppu_ctrl1;
    logic [2:0] fine_x;
    logic       cpu_vram_req;
    logic       cpu_vram_grant;
    logic       status_read;
    logic       vblank;
    logic       nmi;
    logic       frame_done;
    logic       load_error;

    ppu_render_sequencer_if ld_if ();

    ppu_render_sequencer #(
        .SCREEN_ROWS   (ROWS),
        .TILE_W        (TW),
        .VBLANK_CYCLES (VBL),
        .LOAD_TIMEOUT  (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .ppu_ctrl1      (ppu_ctrl1),
        .fine_x         (fine_x),
        .ld             (ld_if),
        .cpu_vram_req   (cpu_vram_req),
        .cpu_vram_grant (cpu_vram_grant),
        .status_read    (status_read),
        .vblank         (vblank),
        .nmi            (nmi),
        .frame_done     (frame_done),
        .load_error     (load_error)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned busy_left = 0;
    logic [17:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tiles start fx pixels left of the edge and advance TW pixels until the
    // right screen edge is covered.
    task automatic build_frame(input int fx);
        int last;
        exp_q.delete();
        last = (fx == 0) ? (256 - int'(TW)) : (256 - fx);
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = -fx; c <= last; c += int'(TW)) begin
                exp_q.push_back({9'(r), 9'(c)});
            end
        end
    endtask

    task automatic loader_step(input logic started);
        if (started) begin
            busy_left = $urandom_range(0, 6);
        end else if (busy_left > 0) begin
            busy_left--;
        end
        ld_if.load_busy = (busy_left > 0);
    endtask

    task automatic wait_start(input string tag);
        int unsigned cyc = 0;
        while (!ld_if.load_start && cyc < 8) begin
            tick();
            cyc++;
        end
        check_val(tag, 32'(ld_if.load_start), 32'd1);
    endtask

    // Entered on the sample showing the frame's first load_start; leaves on
    // the sample right after frame_done.
    task automatic visible_frame(input int fx, input logic [2:0] mid_fx,
                                 input logic read_at_end);
        int unsigned pulses = 0;
        int unsigned grants = 0;
        int unsigned cyc    = 0;
        logic        done   = 1'b0;
        build_frame(fx);
        while (!done && cyc < 20000) begin
            if (ld_if.load_start) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_start", 32'd1, 32'd0);
                end else begin
                    check_val("tile_pos", 32'({ld_if.curr_row, ld_if.curr_col}),
                              32'(exp_q.pop_front()));
                end
                pulses++;
                if (pulses == 5) begin
                    fine_x = mid_fx;
                end
                loader_step(1'b1);
            end else begin
                loader_step(1'b0);
            end
            if (cpu_vram_grant) begin
                grants++;
            end
            if (frame_done) begin
                done        = 1'b1;
                status_read = read_at_end;
            end
            tick();
            cyc++;
        end
        status_read     = 1'b0;
        busy_left       = 0;
        ld_if.load_busy = 1'b0;
        check_val("frame_done_seen", 32'(done), 32'd1);
        check_val("tiles_left", 32'(exp_q.size()), 32'd0);
        check_val("visible_grant", 32'(grants), 32'd0);
    endtask

    task automatic vblank_phase();
        int unsigned g   = 0;
        int unsigned v   = 0;
        int unsigned cyc = 0;
        while (!ld_if.load_start && cyc < 4 * VBL) begin
            if (cpu_vram_grant) g++;
            if (vblank) v++;
            tick();
            cyc++;
        end
        check_val("vbl_restart", 32'(ld_if.load_start), 32'd1);
        check_val("vbl_grant_cycles", 32'(g), 32'(VBL));
        check_val("vbl_flag_cycles", 32'(v), 32'(VBL));
    endtask

    initial begin
        int unsigned cyc;
        int unsigned starts;
        int          fx;
        int          fx2;

        rst             = 1'b1;
        enable          = 1'b0;
        ppu_ctrl1       = 8'h00;
        fine_x          = 3'd0;
        status_read     = 1'b0;
        cpu_vram_req    = 1'b0;
        ld_if.load_busy = 1'b0;
        tick();
        tick();
        check_val("reset_outputs",
                  32'({ld_if.load_start, ld_if.curr_row, ld_if.curr_col, cpu_vram_grant,
                       vblank, nmi, frame_done, load_error}), 32'd0);

        rst          = 1'b0;
        cpu_vram_req = 1'b1;
        tick();
        check_val("idle_grant", 32'(cpu_vram_grant), 32'd1);
        check_val("idle_no_start", 32'(ld_if.load_start), 32'd0);

        // Frame 1: no fine scroll, NMI enabled, fine_x rewritten mid-frame.
        enable    = 1'b1;
        fine_x    = 3'd0;
        ppu_ctrl1 = 8'h80;
        wait_start("frame1_start");
        visible_frame(0, 3'd5, 1'b0);
        check_val("f1_vblank_rise", 32'(vblank), 32'd1);
        check_val("f1_nmi_rise", 32'(nmi), 32'd1);
        vblank_phase();

        // Frame 2: fine_x = 5 from the mid-frame write, NMI disabled,
        // status read coincides with the vblank set.
        ppu_ctrl1 = 8'h00;
        visible_frame(5, 3'd3, 1'b1);
        check_val("set_beats_read", 32'(vblank), 32'd1);
        check_val("f2_nmi_off", 32'(nmi), 32'd0);
        tick();
        tick();
        check_val("f2_nmi_still_off", 32'(nmi), 32'd0);
        ppu_ctrl1 = 8'h80;
        tick();
        check_val("late_nmi_enable", 32'(nmi), 32'd1);
        status_read = 1'b1;
        tick();
        status_read = 1'b0;
        check_val("read_clears_vblank", 32'(vblank), 32'd0);
        check_val("read_clears_nmi", 32'(nmi), 32'd0);

        enable = 1'b0;
        starts = 0;
        for (int i = 0; i < int'(VBL) + 10; i++) begin
            if (ld_if.load_start) starts++;
            tick();
        end
        check_val("disabled_no_start", 32'(starts), 32'd0);
        check_val("idle_after_vbl_grant", 32'(cpu_vram_grant), 32'd1);

        // Loader stuck busy: watchdog must fire and the walk must continue.
        cpu_vram_req    = 1'b0;
        ld_if.load_busy = 1'b1;
        fx              = int'($urandom_range(1, 7));
        fine_x          = 3'(fx);
        enable          = 1'b1;
        wait_start("stuck_start");
        check_val("stuck_pos", 32'({ld_if.curr_row, ld_if.curr_col}),
                  32'({9'd0, 9'(-fx)}));
        cyc = 0;
        while (!load_error && cyc < TMO + 50) begin
            tick();
            cyc++;
        end
        check_val("timeout_cycles", 32'(cyc), 32'(TMO + 2));
        tick();
        check_val("after_timeout_start", 32'(ld_if.load_start), 32'd1);
        check_val("after_timeout_pos", 32'({ld_if.curr_row, ld_if.curr_col}),
                  32'({9'd0, 9'(-fx + int'(TW))}));
        tick();
        tick();
        tick();
        check_val("error_sticky", 32'(load_error), 32'd1);

        // Reset while waiting on the loader.
        rst = 1'b1;
        tick();
        rst             = 1'b0;
        ld_if.load_busy = 1'b0;
        fx2             = int'($urandom_range(0, 7));
        fine_x          = 3'(fx2);
        check_val("midload_reset_outputs",
                  32'({ld_if.load_start, ld_if.curr_row, ld_if.curr_col, cpu_vram_grant,
                       vblank, nmi, frame_done, load_error}), 32'd0);
        tick();
        check_val("post_reset_start", 32'(ld_if.load_start), 32'd1);
        check_val("post_reset_pos", 32'({ld_if.curr_row, ld_if.curr_col}),
                  32'({9'd0, 9'(-fx2)}));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
